md_unit_ctrl: RTL and testbench

Sequencer and owner of the HI/LO register pair for the multiply/divide path. Sits beside the execute stage and consumes the decode stage's multiply/divide start strobes, signedness flag and forwarded operands. It runs a fixed-latency multiply or a 32-iteration restoring divide, writes the result into HI/LO and serves MTHI/MTLO writes and MFHI/MFLO reads. While an operation is in flight it raises a stall so that no HI/LO consumer or second multiply/divide issues early.

---
 rtl/md_unit_ctrl_pkg.sv | 20 ++
 rtl/md_unit_ctrl_if.sv | 30 +++
 rtl/md_div_iter.sv | 54 +++++
 rtl/md_unit_ctrl.sv | 135 +++++++++++++
 tb/tb_md_unit_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/md_unit_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_unit_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_t;

    localparam int          DIV_ITERS   = 32;
    localparam int          MUL_LAT_DEF = 3;
    localparam logic [31:0] DIVZERO_LO  = 32'hFFFFFFFF;

    // Two's complement negate when asked, pass through otherwise.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic do_neg);
        return do_neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// Decode-side bundle of the multiply/divide unit: start strobes, operands,
// MT writes, MF read requests and the HI/LO/busy/stall returns.
interface md_unit_ctrl_if;
    logic        de_mult_en;
    logic        de_div_en;
    logic        de_is_signed;
    logic [31:0] de_MD_src1;
    logic [31:0] de_MD_src2;
    logic        mt_hi_wen;
    logic        mt_lo_wen;
    logic [31:0] mt_wdata;
    logic        rd_hi_req;
    logic        rd_lo_req;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;
    logic        md_busy;
    logic        md_stall;

    modport master (
        output de_mult_en, de_div_en, de_is_signed, de_MD_src1, de_MD_src2,
        output mt_hi_wen, mt_lo_wen, mt_wdata, rd_hi_req, rd_lo_req,
        input  hi_rdata, lo_rdata, md_busy, md_stall
    );

    modport slave (
        input  de_mult_en, de_div_en, de_is_signed, de_MD_src1, de_MD_src2,
        input  mt_hi_wen, mt_lo_wen, mt_wdata, rd_hi_req, rd_lo_req,
        output hi_rdata, lo_rdata, md_busy, md_stall
    );
endinterface

// File: rtl/md_div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per clock,
// loaded on start, finishing DIV_ITERS edges later.
module md_div_iter
    import md_unit_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [5:0]  cnt;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic        ge;

    // Trial subtract of the shifted partial remainder. With rem < divisor the
    // 33-bit difference is negative exactly when bit 32 is set.
    always_comb begin
        rem_sh = {rem, quo[31]};
        diff   = rem_sh - {1'b0, dvs};
        ge     = ~diff[32];
    end

    // Shift/subtract iteration with the down-counting iteration count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
            cnt <= 6'(DIV_ITERS);
        end else if (cnt != 6'd0) begin
            rem <= ge ? diff[31:0] : rem_sh[31:0];
            quo <= {quo[30:0], ge};
            cnt <= cnt - 6'd1;
        end
    end

    // High during the cycle whose closing edge performs the final iteration.
    assign done = (cnt == 6'd1);
    assign q    = quo;
    assign r    = rem;
endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer and HI/LO owner. Accepts starts only when idle,
// runs a fixed-latency multiply or a 32-step divide, and stalls decode while
// any HI/LO consumer or new start would race the in-flight operation.
module md_unit_ctrl
    import md_unit_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    md_unit_ctrl_if.slave  bus
);
    md_state_t   state;
    logic        busy_q;
    logic [3:0]  mul_cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sgn_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept_mul;
    logic        accept_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic signed [32:0] ext_a;
    logic signed [32:0] ext_b;
    logic [63:0] prod;
    logic        q_neg;
    logic        r_neg;

    // Start decode and magnitudes for the divider, taken straight from decode
    // so the divider loads on the accept edge itself.
    always_comb begin
        accept_mul = (state == IDLE) && bus.de_mult_en;
        accept_div = (state == IDLE) && !bus.de_mult_en && bus.de_div_en;
        mag_a      = neg_if(bus.de_MD_src1, bus.de_is_signed & bus.de_MD_src1[31]);
        mag_b      = neg_if(bus.de_MD_src2, bus.de_is_signed & bus.de_MD_src2[31]);
    end

    // Product of the latched operands; timed as a MUL_LAT-cycle multicycle path
    // since op_a/op_b hold steady until the MUL state consumes it.
    always_comb begin
        ext_a = {sgn_q & op_a[31], op_a};
        ext_b = {sgn_q & op_b[31], op_b};
        prod  = 64'(ext_a * ext_b);
        q_neg = sgn_q & (op_a[31] ^ op_b[31]);
        r_neg = sgn_q & op_a[31];
    end

    md_div_iter u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (accept_div),
        .dividend (mag_a),
        .divisor  (mag_b),
        .done     (div_done),
        .q        (div_q),
        .r        (div_r)
    );

    // Sequencer: accept, count down the multiply, wait out the divide, then
    // commit to HI/LO. MT writes land only in idle cycles without a start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            mul_cnt <= '0;
            op_a    <= '0;
            op_b    <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_mul || accept_div) begin
                        op_a   <= bus.de_MD_src1;
                        op_b   <= bus.de_MD_src2;
                        sgn_q  <= bus.de_is_signed;
                        busy_q <= 1'b1;
                        if (accept_mul) begin
                            state   <= MUL;
                            mul_cnt <= 4'(MUL_LAT - 1);
                        end else begin
                            state <= DIV;
                        end
                    end else begin
                        if (bus.mt_hi_wen) hi_q <= bus.mt_wdata;
                        if (bus.mt_lo_wen) lo_q <= bus.mt_wdata;
                    end
                end
                MUL: begin
                    if (mul_cnt == 4'd0) begin
                        hi_q   <= prod[63:32];
                        lo_q   <= prod[31:0];
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        mul_cnt <= mul_cnt - 4'd1;
                    end
                end
                DIV: begin
                    if (div_done) state <= FIX;
                end
                FIX: begin
                    // Zero divisor reports the raw dividend, never sign-fixed.
                    if (op_b == 32'd0) begin
                        lo_q <= DIVZERO_LO;
                        hi_q <= op_a;
                    end else begin
                        lo_q <= neg_if(div_q, q_neg);
                        hi_q <= neg_if(div_r, r_neg);
                    end
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.md_busy  = busy_q;
    assign bus.md_stall = busy_q & (bus.de_mult_en | bus.de_div_en |
                                    bus.rd_hi_req  | bus.rd_lo_req |
                                    bus.mt_hi_wen  | bus.mt_lo_wen);
    assign bus.hi_rdata = hi_q;
    assign bus.lo_rdata = lo_q;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: expected HI/LO pushed at start, popped
// and compared when md_busy drops.
module tb_md_unit_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [63:0] sb_q[$];

    md_unit_ctrl_if bus();

    md_unit_ctrl #(.MUL_LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input bit is_mul, input bit sgn,
                                           input logic [31:0] a, input logic [31:0] b);
        longint la, lb, p, qq, rr;
        logic [63:0] u;
        la = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        lb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (is_mul) begin
            p = la * lb;
            return 64'(p);
        end
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (sgn) begin
            qq = la / lb;
            rr = la % lb;
            return {rr[31:0], qq[31:0]};
        end
        u = {a % b, a / b};
        return u;
    endfunction

    // Start an op in the current cycle, then follow it to completion.
    task automatic run_op(input bit is_mul, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat,
                          input bit hold_rd, input bit mt_with, input bit poke);
        logic [31:0] lo_before;
        logic [63:0] got;
        int cycles;
        int stall_bad;
        sb_q.push_back(exp);
        lo_before = bus.lo_rdata;
        bus.de_mult_en   = is_mul;
        bus.de_div_en    = !is_mul;
        bus.de_is_signed = sgn;
        bus.de_MD_src1   = a;
        bus.de_MD_src2   = b;
        if (mt_with) begin
            bus.mt_lo_wen = 1'b1;
            bus.mt_wdata  = 32'hDEADBEEF;
        end
        @(posedge clk); #1;
        bus.de_mult_en   = 1'b0;
        bus.de_div_en    = 1'b0;
        bus.mt_lo_wen    = 1'b0;
        bus.de_MD_src1   = $urandom;
        bus.de_MD_src2   = $urandom;
        bus.de_is_signed = ~sgn;
        if (mt_with) chk("mt_drop", {32'b0, bus.lo_rdata}, {32'b0, lo_before});
        if (hold_rd) bus.rd_lo_req = 1'b1;
        cycles = 0;
        stall_bad = 0;
        while (bus.md_busy && cycles < 200) begin
            if (hold_rd && !bus.md_stall) stall_bad++;
            if (poke && cycles == 5) begin
                bus.de_mult_en = 1'b1;
                #1;
                chk("busy_stall", {63'b0, bus.md_stall}, 64'd1);
            end
            cycles++;
            @(posedge clk); #1;
            bus.de_mult_en = 1'b0;
        end
        chk("latency", 64'(cycles), 64'(lat));
        if (hold_rd) begin
            chk("stall_held", 64'(stall_bad), 64'd0);
            chk("stall_rel", {63'b0, bus.md_stall}, 64'd0);
            chk("mflo_read", {32'b0, bus.lo_rdata}, {32'b0, exp[31:0]});
            bus.rd_lo_req = 1'b0;
        end
        got = sb_q.pop_front();
        chk("hi", {32'b0, bus.hi_rdata}, {32'b0, got[63:32]});
        chk("lo", {32'b0, bus.lo_rdata}, {32'b0, got[31:0]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        bit rm, rs;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.de_mult_en = 0; bus.de_div_en = 0; bus.de_is_signed = 0;
        bus.de_MD_src1 = 0; bus.de_MD_src2 = 0;
        bus.mt_hi_wen = 0; bus.mt_lo_wen = 0; bus.mt_wdata = 0;
        bus.rd_hi_req = 0; bus.rd_lo_req = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  {63'b0, bus.md_busy},  64'd0);
        chk("rst_stall", {63'b0, bus.md_stall}, 64'd0);
        chk("rst_hi",    {32'b0, bus.hi_rdata}, 64'd0);
        chk("rst_lo",    {32'b0, bus.lo_rdata}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(1, 1, 32'hFFFFFFFE, 32'h3, {32'hFFFFFFFF, 32'hFFFFFFFA}, 3, 0, 0, 0);
        run_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 3, 0, 0, 0);
        run_op(0, 1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1, 0, 0);
        run_op(0, 0, 32'd100, 32'd0, {32'd100, 32'hFFFFFFFF}, 33, 0, 0, 0);
        run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 0, 0, 0);
        run_op(0, 1, 32'hFFFFFF9C, 32'd0, {32'hFFFFFF9C, 32'hFFFFFFFF}, 33, 0, 0, 0);

        // MTHI / MTLO in idle
        bus.mt_hi_wen = 1'b1;
        bus.mt_wdata  = 32'h12345678;
        @(posedge clk); #1;
        bus.mt_hi_wen = 1'b0;
        chk("mthi", {32'b0, bus.hi_rdata}, 64'h12345678);
        bus.mt_lo_wen = 1'b1;
        bus.mt_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.mt_lo_wen = 1'b0;
        chk("mtlo", {32'b0, bus.lo_rdata}, 64'hCAFEF00D);

        // MTLO with a divide start is dropped; a mult strobe mid-divide is ignored
        run_op(0, 0, 32'd50, 32'd7, {32'd1, 32'd7}, 33, 0, 1, 1);
        run_op(0, 1, 32'd50, 32'hFFFFFFF9, {32'd1, 32'hFFFFFFF9}, 33, 0, 0, 1);

        // Reset in the middle of a divide
        bus.de_div_en = 1'b1;
        bus.de_MD_src1 = 32'd1000;
        bus.de_MD_src2 = 32'd3;
        @(posedge clk); #1;
        bus.de_div_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.rd_hi_req = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy",  {63'b0, bus.md_busy},  64'd0);
        chk("mid_rst_stall", {63'b0, bus.md_stall}, 64'd0);
        chk("mid_rst_hi",    {32'b0, bus.hi_rdata}, 64'd0);
        chk("mid_rst_lo",    {32'b0, bus.lo_rdata}, 64'd0);
        bus.rd_hi_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(1, 0, 32'd2, 32'd3, {32'd0, 32'd6}, 3, 0, 0, 0);

        // Random back-to-back mix checked against the reference model
        for (int i = 0; i < 12; i++) begin
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (!rm && $urandom_range(0, 3) == 0) rb = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
            run_op(rm, rs, ra, rb, ref_op(rm, rs, ra, rb), rm ? 3 : 33, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
